// File: rtl/dma_io_rx_channel_pkg.sv
// Shared constants, FSM state type and helpers for the DMA IO receive channel.
package dma_pkg;

    localparam int DATA_W  = 32;   // databus and memory word width
    localparam int MEM_AW  = 13;   // memory word-address width
    localparam int BUF_AW  = 5;    // device buffer address width
    localparam int IDX_W   = 9;    // device index width: {CS, addr[7:0]}
    localparam int CS_BIT  = 8;    // chip-select position inside io_index
    localparam int MAX_LEN = 32;   // maximum words per transfer
    localparam int LEN_W   = 6;    // width of length / word counters

    // Channel sequencing states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACK  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } dma_state_t;

    // Clamp a requested length to the largest transfer the channel supports.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(MAX_LEN)) begin
            return LEN_W'(MAX_LEN);
        end
        return len;
    endfunction

    // Device index for a buffer read: chip select set, unused address bits zero.
    function automatic logic [IDX_W-1:0] rd_index(input logic [BUF_AW-1:0] ptr);
        return {1'b1, {(CS_BIT-BUF_AW){1'b0}}, ptr};
    endfunction

endpackage

// File: rtl/dma_io_rx_channel_if.sv
// Device (Ack/index/IOWrite/databus) and memory write-port signals of the channel.
interface dma_io_rx_channel_if;
    import dma_pkg::*;

    // IO device side
    logic              io_req;
    logic              io_ack;
    logic [IDX_W-1:0]  io_index;
    logic              io_write;
    logic [DATA_W-1:0] io_rdata;

    // Memory write port
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;

    // The DMA channel drives the device handshake and the memory write port.
    modport master (
        input  io_req,
        input  io_rdata,
        input  mem_ready,
        output io_ack,
        output io_index,
        output io_write,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    // The device / memory side of the same signals.
    modport slave (
        output io_req,
        output io_rdata,
        output mem_ready,
        input  io_ack,
        input  io_index,
        input  io_write,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/dma_io_rx_channel_xfer_counter.sv
// Transfer bookkeeping: buffer read pointer, words written and memory
// address generation, with the terminal-count compare for the last word.
module dma_xfer_counter
    import dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,        // start of a transfer
    input  logic              advance,     // one word accepted by memory
    input  logic [MEM_AW-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic [BUF_AW-1:0] rd_ptr,
    output logic [LEN_W-1:0]  words_done,
    output logic [MEM_AW-1:0] wr_addr,
    output logic              last         // the word being written is the final one
);

    logic [BUF_AW-1:0] ptr;
    logic [LEN_W-1:0]  count;
    logic [MEM_AW-1:0] addr;
    logic [LEN_W-1:0]  len_lat;

    // Latch the transfer parameters at start, step everything on each accepted word.
    // The address counter wraps naturally modulo the memory size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            count   <= '0;
            addr    <= '0;
            len_lat <= '0;
        end else if (load) begin
            ptr     <= '0;
            count   <= '0;
            addr    <= base;
            len_lat <= sat_len(len);
        end else if (advance) begin
            ptr     <= ptr + 1'b1;
            count   <= count + 1'b1;
            addr    <= addr + 1'b1;
        end
    end

    assign rd_ptr     = ptr;
    assign words_done = count;
    assign wr_addr    = addr;
    assign last       = ((count + LEN_W'(1)) == len_lat);

endmodule

// File: rtl/dma_io_rx_channel.sv
// DMA receive channel: answers a device request with Ack, reads the device
// buffer word by word over the index/databus interface and writes each word
// into memory, finishing with a sticky completion interrupt.
module dma_io_rx_channel
    import dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MEM_AW-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_en,
    input  logic              irq_clr,
    dma_io_rx_channel_if.master bus,
    output logic              busy,
    output logic              irq,
    output logic [LEN_W-1:0]  words_done
);

    dma_state_t        state;
    logic              armed;       // request has been seen low since the last transfer
    logic              ack;
    logic [IDX_W-1:0]  index;
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [DATA_W-1:0] wdata;

    logic              start;
    logic              advance;
    logic [BUF_AW-1:0] cnt_rd_ptr;
    logic [MEM_AW-1:0] cnt_addr;
    logic              cnt_last;

    // A transfer begins only on a fresh request while the channel is enabled.
    assign start   = (state == IDLE) && cfg_en && bus.io_req && armed;
    assign advance = (state == WR) && bus.mem_ready;

    dma_xfer_counter u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start),
        .advance    (advance),
        .base       (cfg_base),
        .len        (cfg_len),
        .rd_ptr     (cnt_rd_ptr),
        .words_done (words_done),
        .wr_addr    (cnt_addr),
        .last       (cnt_last)
    );

    // Channel sequencer with all device/memory outputs registered. A dropped
    // request ends the transfer at the next state boundary; a write already
    // presented to memory is always allowed to complete first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
            ack   <= 1'b0;
            index <= '0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            busy  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            // Clear first so that any completion below overrides it.
            if (irq_clr) begin
                irq <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!bus.io_req) begin
                        armed <= 1'b1;
                    end
                    if (start) begin
                        armed <= 1'b0;
                        if (cfg_len == '0) begin
                            state <= DONE;
                            irq   <= 1'b1;
                        end else begin
                            state <= ACK;
                            ack   <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (!bus.io_req) begin
                        state <= DONE;
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                        irq   <= 1'b1;
                    end else begin
                        state <= RD;
                        index <= rd_index(cnt_rd_ptr);
                    end
                end
                RD: begin
                    // The device returns the addressed word while the index is held.
                    index <= '0;
                    if (!bus.io_req) begin
                        state <= DONE;
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                        irq   <= 1'b1;
                    end else begin
                        state <= WR;
                        wdata <= bus.io_rdata;
                        we    <= 1'b1;
                        addr  <= cnt_addr;
                    end
                end
                WR: begin
                    if (bus.mem_ready) begin
                        we <= 1'b0;
                        if (cnt_last || !bus.io_req) begin
                            state <= DONE;
                            ack   <= 1'b0;
                            busy  <= 1'b0;
                            irq   <= 1'b1;
                        end else begin
                            state <= RD;
                            index <= rd_index(cnt_rd_ptr + 1'b1);
                        end
                    end
                end
                DONE: begin
                    irq   <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.io_ack    = ack;
    assign bus.io_index  = index;
    assign bus.io_write  = 1'b0;   // read-only channel
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;

endmodule

// File: tb/tb_dma_io_rx_channel.sv
// Bench for the DMA receive channel: device buffer model, memory ready model,
// transaction-level expected write list and a per-cycle compare process.
module tb_dma_io_rx_channel;
    import dma_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [MEM_AW-1:0] cfg_base = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              cfg_en = 1'b0;
    logic              irq_clr = 1'b0;
    logic              busy;
    logic              irq;
    logic [LEN_W-1:0]  words_done;

    always #5 clk = ~clk;

    dma_io_rx_channel_if bus_if ();

    logic [DATA_W-1:0] dev_buf [32];
    logic [DATA_W-1:0] junk = '0;

    // Device databus: addressed word while CS is up, garbage otherwise.
    assign bus_if.io_rdata = bus_if.io_index[CS_BIT] ? dev_buf[bus_if.io_index[BUF_AW-1:0]] : junk;
    always @(posedge clk) junk <= $urandom;

    dma_io_rx_channel dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .cfg_en     (cfg_en),
        .irq_clr    (irq_clr),
        .bus        (bus_if),
        .busy       (busy),
        .irq        (irq),
        .words_done (words_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [MEM_AW-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               exp_q[$];
    bit                chk_on = 1'b0;
    int                rd_cnt, acc_cnt, stall_cnt, ack_cnt;
    bit                prev_stall;
    logic [MEM_AW-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;
    logic [MEM_AW-1:0] log_addr [64];
    logic [DATA_W-1:0] log_data [64];

    // Per-cycle compare against the expected write list and protocol rules.
    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("io_write", bus_if.io_write, 0);
            chk("busy_vs_ack", busy, bus_if.io_ack);
            if (bus_if.io_index[CS_BIT]) begin
                chk("rd_index", bus_if.io_index, {1'b1, 8'(rd_cnt)});
                chk("rd_ack", bus_if.io_ack, 1);
                rd_cnt++;
            end
            if (bus_if.mem_we) begin
                if (prev_stall) begin
                    chk("stall_addr", bus_if.mem_addr, prev_addr);
                    chk("stall_data", bus_if.mem_wdata, prev_data);
                end
                if (bus_if.mem_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_write actual_addr=0x%0h required=no_write", bus_if.mem_addr);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        chk("wr_addr", bus_if.mem_addr, e.a);
                        chk("wr_data", bus_if.mem_wdata, e.d);
                    end
                    log_addr[acc_cnt[5:0]] = bus_if.mem_addr;
                    log_data[acc_cnt[5:0]] = bus_if.mem_wdata;
                    acc_cnt++;
                    prev_stall = 1'b0;
                end else begin
                    stall_cnt++;
                    prev_stall = 1'b1;
                    prev_addr  = bus_if.mem_addr;
                    prev_data  = bus_if.mem_wdata;
                end
            end else begin
                prev_stall = 1'b0;
            end
            if (bus_if.io_ack) ack_cnt++;
        end
    end

    // One transfer: model computes the expected writes, stimulus drives the
    // device request / memory ready, then completion state is checked.
    task automatic run_xfer(input logic [MEM_AW-1:0] base, input int len, input int abort_k,
                            input int stall_mode, input bit clr_at_done, input bit fixed,
                            input bit scramble);
        int lsat, n, it, stall_seen, exp_ack;
        bit seen;
        cfg_en = 1'b0;
        bus_if.io_req = 1'b0;
        bus_if.mem_ready = 1'b1;
        irq_clr = 1'b0;
        @(posedge clk); #1;
        if (irq) begin
            irq_clr = 1'b1;
            @(posedge clk); #1;
            irq_clr = 1'b0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) dev_buf[i] = fixed ? (32'hA0 + i) : $urandom;
        lsat = (len > MAX_LEN) ? MAX_LEN : len;
        n = (abort_k >= 0 && abort_k < lsat) ? abort_k : lsat;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back('{base + MEM_AW'(i), dev_buf[i]});
        rd_cnt = 0; acc_cnt = 0; stall_cnt = 0; ack_cnt = 0; prev_stall = 1'b0;
        stall_seen = 0;
        chk_on = 1'b1;
        cfg_base = base;
        cfg_len = LEN_W'(len);
        cfg_en = 1'b1;
        bus_if.io_req = 1'b1;
        seen = 1'b0;
        it = 0;
        while (!seen && it < 600) begin
            @(posedge clk); #1;
            it++;
            if (irq) begin
                seen = 1'b1;
                if (clr_at_done) irq_clr = 1'b1;
            end else begin
                bus_if.mem_ready = 1'b1;
                if (stall_mode == 1 && bus_if.mem_we && acc_cnt == 0 && stall_seen < 3) begin
                    bus_if.mem_ready = 1'b0;
                    stall_seen++;
                end else if (stall_mode == 2) begin
                    bus_if.mem_ready = ($urandom_range(0, 99) >= 40);
                end
                if (abort_k == 0 && bus_if.io_ack) bus_if.io_req = 1'b0;
                if (abort_k > 0 && bus_if.mem_we && bus_if.mem_ready && acc_cnt + 1 == abort_k)
                    bus_if.io_req = 1'b0;
                if (scramble && busy) begin
                    cfg_base = MEM_AW'($urandom);
                    cfg_len = LEN_W'($urandom);
                    cfg_en = 1'($urandom);
                end
            end
        end
        exp_ack = (lsat == 0) ? 0 : 1 + 2 * n + stall_cnt;
        $display("xfer base=%0d len=%0d abort=%0d mode=%0d expect_words=%0d cycles=%0d",
                 base, len, abort_k, stall_mode, n, it);
        chk("done_seen", seen, 1);
        chk("irq_latency", it, exp_ack + 1);
        chk("ack_cycles", ack_cnt, exp_ack);
        chk("words_done", words_done, n);
        chk("done_busy", busy, 0);
        chk("done_ack", bus_if.io_ack, 0);
        @(posedge clk); #1;
        irq_clr = 1'b0;
        chk("irq_sticky", irq, 1);
        cfg_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_restart", busy, 0);
        end
        chk("wr_count", acc_cnt, n);
        chk("queue_empty", exp_q.size(), 0);
        irq_clr = 1'b1;
        @(posedge clk); #1;
        irq_clr = 1'b0;
        chk("irq_cleared", irq, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bus_if.io_req = 1'b0;
        bus_if.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", bus_if.io_ack, 0);
        chk("rst_index", bus_if.io_index, 0);
        chk("rst_we", bus_if.mem_we, 0);
        chk("rst_addr", bus_if.mem_addr, 0);
        chk("rst_wdata", bus_if.mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_words", words_done, 0);
        rst_n = 1'b1;

        // Basic transfer with known buffer contents.
        run_xfer(13'd100, 4, -1, 0, 1'b0, 1'b1, 1'b0);
        chk("basic_addr0", log_addr[0], 100);
        chk("basic_addr3", log_addr[3], 103);
        chk("basic_data0", log_data[0], 32'hA0);
        chk("basic_data3", log_data[3], 32'hA3);
        chk("basic_ack9", ack_cnt, 9);

        // Backpressure on the first word.
        run_xfer(13'd200, 2, -1, 1, 1'b0, 1'b1, 1'b0);
        chk("bp_stalls", stall_cnt, 3);
        chk("bp_writes", acc_cnt, 2);
        chk("bp_ack", ack_cnt, 8);

        // Zero length.
        run_xfer(13'd300, 0, -1, 0, 1'b0, 1'b0, 1'b0);
        chk("zero_ack", ack_cnt, 0);
        chk("zero_writes", acc_cnt, 0);

        // Abort after the third write.
        run_xfer(13'd400, 8, 3, 0, 1'b0, 1'b0, 1'b0);
        chk("abort_writes", acc_cnt, 3);

        // Address wrap, length saturation, clear coincident with completion.
        run_xfer(13'd8190, 40, -1, 0, 1'b1, 1'b0, 1'b0);
        chk("wrap_a0", log_addr[0], 8190);
        chk("wrap_a1", log_addr[1], 8191);
        chk("wrap_a2", log_addr[2], 0);
        chk("wrap_a31", log_addr[31], 29);
        chk("wrap_count", acc_cnt, 32);

        // Reset while a write is pending.
        chk_on = 1'b0;
        cfg_en = 1'b0;
        bus_if.io_req = 1'b0;
        bus_if.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cfg_base = 13'd50;
        cfg_len = 6'd8;
        cfg_en = 1'b1;
        bus_if.io_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (bus_if.mem_we) found = 1'b1;
        end
        chk("midwr_we_seen", found, 1);
        rst_n = 1'b0;
        #1;
        chk("midwr_rst_ack", bus_if.io_ack, 0);
        chk("midwr_rst_we", bus_if.mem_we, 0);
        chk("midwr_rst_addr", bus_if.mem_addr, 0);
        chk("midwr_rst_wdata", bus_if.mem_wdata, 0);
        chk("midwr_rst_index", bus_if.io_index, 0);
        chk("midwr_rst_busy", busy, 0);
        chk("midwr_rst_words", words_done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_if.mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("post_rst_we", bus_if.mem_we, 0);
            chk("post_rst_busy", busy, 0);
        end
        chk("post_rst_irq", irq, 0);
        $display("reset mid-write sequence complete");

        // Randomized transfers.
        for (int r = 0; r < 25; r++) begin
            int len, lsat, ab, mode;
            len = $urandom_range(0, 63);
            lsat = (len > MAX_LEN) ? MAX_LEN : len;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lsat) : -1;
            mode = $urandom_range(0, 1) * 2;
            run_xfer(MEM_AW'($urandom), len, ab, mode, 1'($urandom), 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_io_rx_channel.md
Name: dma_io_rx_channel

Overview:
DMA channel engine that services a buffered IO device: detects the device's GPIO request, asserts Ack, issues addressed buffer reads over the device index/databus interface and writes each returned word into system memory. It is the initiator/reader end of the device's Ack/index/IOWrite protocol and sits between the IO device and the memory write port. It raises a completion interrupt and acknowledges the device when the programmed word count is exhausted.

Parameters:
DATA_W, 32, databus and memory word width
MEM_AW, 13, memory word-address width (8192 words)
BUF_AW, 5, device buffer address width (32 entries; device index uses 8 address bits, upper bits zero)
MAX_LEN, 32, maximum words per transfer

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_base  in  MEM_AW  memory start word address, sampled at start
cfg_len  in  6  words to move (0..MAX_LEN), sampled at start
cfg_en  in  1  channel enable; 0 holds channel in IDLE
irq_clr  in  1  clears irq (single-cycle pulse)
io_req  in  1  device request (device GPIO), level
io_ack  out  1  Ack to device
io_index  out  9  {CS, buffer address[7:0]} to device
io_write  out  1  IOWrite to device; this block only reads, drives 0 while busy
io_rdata  in  DATA_W  device databus, valid the cycle after the read is issued
mem_we  out  1  memory write strobe
mem_addr  out  MEM_AW  memory write address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory accepts write this cycle when 1 and mem_we=1
busy  out  1  transfer in progress
irq  out  1  sticky completion interrupt
words_done  out  6  words written so far in current/last transfer

Behaviour:
- Reset (async, rst_n=0): state IDLE; io_ack=0, io_index=0, io_write=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, irq=0, words_done=0. Reset mid-transfer abandons it; no further memory writes.
- States: IDLE, ACK, RD, WR, DONE.
- IDLE: if cfg_en=1 and io_req=1 -> latch base/len, words_done=0, -> ACK. len=0 -> DONE directly (no Ack pulse, no writes).
- ACK: io_ack=1 (held until DONE), busy=1; next cycle -> RD.
- RD: drive io_index={1'b1, 3'b0, rd_ptr}, io_write=0 for one cycle; next cycle -> WR, capture io_rdata into mem_wdata.
- WR: mem_we=1, mem_addr=base+words_done (wraps modulo 2^MEM_AW); hold until mem_ready=1. On accept: words_done+1, rd_ptr+1; if words_done+1==len -> DONE else -> RD. Throughput: one word per 2 cycles with mem_ready=1.
- io_index CS bit=0 in all states except RD; io_write=0 always when busy, 0 in IDLE.
- DONE: io_ack=0, busy=0, irq=1; -> IDLE next cycle. Channel does not restart until io_req has been seen low at least one cycle after DONE (prevents re-trigger on stale request).
- io_req falling while busy: abort at next state boundary (after any pending WR accept), -> DONE with words_done = words actually written; irq still set.
- cfg_en falling while busy: ignored until current transfer ends.
- irq: set in DONE, cleared by irq_clr; simultaneous set and clear -> set wins.
- cfg_base/cfg_len changes while busy have no effect. cfg_len>MAX_LEN saturates to MAX_LEN.

Decomposition:
- Shared package dma_pkg: state enum (IDLE/ACK/RD/WR/DONE), DATA_W, MEM_AW, BUF_AW, CS bit position (8), MAX_LEN constants.
- One natural sub-module: dma_xfer_counter (rd_ptr/words_done/address generation with terminal-count compare); FSM stays in top.

Test Plan:
- Reset mid-WR: rst_n low while mem_we=1 -> all outputs 0 same cycle, no write after release, irq=0.
- Basic transfer: cfg_base=100, cfg_len=4, device buffer 0..3 = A0,A1,A2,A3, io_req=1, mem_ready=1 -> mem writes (100,A0)…(103,A3), io_index 0x100..0x103, io_ack high 9 cycles, irq=1, words_done=4.
- Backpressure: cfg_len=2, mem_ready low 3 cycles on first word -> mem_we held with stable addr/data, exactly 2 writes, order preserved.
- Zero length: cfg_len=0, io_req=1 -> no io_ack, no mem_we, irq=1 next cycle, words_done=0.
- Abort: cfg_len=8, drop io_req after third write accepted -> DONE, words_done=3, io_ack=0, no 4th write; no restart until io_req low then high.
- Wrap and saturate: cfg_base=8190, cfg_len=40 -> 32 writes at 8190, 8191, 0..29; irq_clr coincident with DONE -> irq remains 1.
